fifo_ctrl: RTL and testbench

Single-clock controller that sequences the team's FIFO memory block. It owns the write and read pointers and drives the memory's address, enable and data ports. It adds a valid/ready handshake on both sides and a show-ahead output stage that hides the memory's one-cycle registered read latency. It reports occupancy, full/almost thresholds and supports a synchronous flush.

---
 rtl/fifo_ctrl.sv | 91 +++++++++
 tb/tb_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/handshake controller for an external registered-read FIFO memory; 2-edge write-to-present latency, 1 word/cycle.
// Writes stall on full or flush; a show-ahead stage refills whenever it is empty or being consumed.
module fifo_ctrl #(
  parameter int N        = 8,
  parameter int DEEP     = 8,
  parameter int AF_LEVEL = (1 << DEEP) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic            clk_in,
  input  logic            arst_n,
  input  logic            flush,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [N-1:0]    wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [N-1:0]    rd_data,
  output logic [N-1:0]    mem_data_in,
  output logic [DEEP:0]   mem_address_w,
  output logic [DEEP:0]   mem_address_r,
  output logic            mem_w_en,
  output logic            mem_r_en,
  input  logic [N-1:0]    mem_data_o,
  output logic [DEEP:0]   count,
  output logic            full,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam logic [DEEP:0] DEPTH_C = {1'b1, {DEEP{1'b0}}};
  localparam logic [DEEP:0] AF_C    = (DEEP+1)'(AF_LEVEL);
  localparam logic [DEEP:0] AE_C    = (DEEP+1)'(AE_LEVEL);
  localparam logic [DEEP:0] ONE_C   = (DEEP+1)'(1);

  logic [DEEP:0] wptr_q, wptr_d;
  logic [DEEP:0] rptr_q, rptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DEEP:0] cnt;
  logic          accept;
  logic          fetch;

  assign cnt          = wptr_q - rptr_q;
  assign full         = (cnt == DEPTH_C);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign count        = cnt;

  assign wr_ready      = ~full & ~flush;
  assign accept        = wr_valid & wr_ready;
  assign mem_w_en      = accept;
  assign mem_address_w = wptr_q;
  assign mem_data_in   = wr_data;

  // Emptiness is judged on the registered wptr, so a word is never read on the edge it is written.
  assign fetch         = (cnt != '0) & (~rd_valid_q | rd_ready) & ~flush;
  assign mem_r_en      = fetch;
  assign mem_address_r = rptr_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = mem_data_o;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    if (flush) begin
      rptr_d     = wptr_q;
      rd_valid_d = 1'b0;
    end else begin
      if (accept) wptr_d = wptr_q + ONE_C;
      if (fetch) begin
        rptr_d     = rptr_q + ONE_C;
        rd_valid_d = 1'b1;
      end else if (rd_valid_q && rd_ready) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural registered-read memory and a queue scoreboard.
module tb_fifo_ctrl;
  localparam int N = 8;
  localparam int DEEP = 3;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            flush = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [N-1:0]    wr_data = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [N-1:0]    rd_data;
  logic [N-1:0]    mem_data_in;
  logic [DEEP:0]   mem_address_w;
  logic [DEEP:0]   mem_address_r;
  logic            mem_w_en;
  logic            mem_r_en;
  logic [N-1:0]    mem_data_o = '0;
  logic [DEEP:0]   count;
  logic            full;
  logic            almost_full;
  logic            almost_empty;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  logic [N-1:0] sb[$];
  logic [N-1:0] mem [0:(1<<DEEP)-1];

  always #5 clk = ~clk;

  fifo_ctrl #(.N(N), .DEEP(DEEP), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk_in(clk), .arst_n(arst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_data_in(mem_data_in), .mem_address_w(mem_address_w), .mem_address_r(mem_address_r),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_data_o(mem_data_o),
    .count(count), .full(full), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_address_w[DEEP-1:0]] <= mem_data_in;
    if (mem_r_en) mem_data_o <= mem[mem_address_r[DEEP-1:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accepted write, pop/compare on consumed read.
  always @(negedge clk) begin
    if (!arst_n) begin
      sb.delete();
    end else begin
      if (wr_valid && wr_ready) sb.push_back(wr_data);
      if (rd_valid && rd_ready && !flush) begin
        if (sb.size() == 0) chk("rd_unexpected", {24'h0, rd_data}, 32'hDEAD);
        else begin
          chk("rd_data", {24'h0, rd_data}, {24'h0, sb.pop_front()});
          rx_cnt++;
        end
      end
      if (flush) sb.delete();
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int max_cnt;
    int rx0;

    // Reset state
    #12;
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_w_en", mem_w_en, 0);
    chk("rst_r_en", mem_r_en, 0);
    arst_n = 1'b1;

    // Single word latency
    step();
    wr_valid = 1; wr_data = 8'hA5;
    step();
    wr_valid = 0;
    @(negedge clk);
    chk("lat_rd_valid_e1", rd_valid, 0);
    chk("lat_count_e1", count, 1);
    chk("lat_r_en_e1", mem_r_en, 1);
    step();
    @(negedge clk);
    chk("lat_rd_valid_e2", rd_valid, 1);
    chk("lat_rd_data", rd_data, 8'hA5);
    chk("lat_count_e2", count, 0);
    chk("lat_ae", almost_empty, 1);
    step();
    rd_ready = 1;
    step();
    rd_ready = 0;
    @(negedge clk);
    chk("lat_drained", rd_valid, 0);

    // Fill to full with reader stalled
    step();
    for (int i = 1; i <= 9; i++) begin
      wr_valid = 1; wr_data = N'(i);
      step();
    end
    wr_data = 8'h0A;
    @(negedge clk);
    chk("full_count", count, 8);
    chk("full_full", full, 1);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_af", almost_full, 1);
    chk("full_head", rd_data, 8'h01);
    step();
    @(negedge clk);
    chk("full_10th_rejected", count, 8);

    // Drain at full rate
    step();
    wr_valid = 0; rd_ready = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("drain_no_bubble", rd_valid, 1);
      if (i == 1) chk("drain_wr_ready_back", wr_ready, 1);
      step();
    end
    @(negedge clk);
    chk("drain_done_rd_valid", rd_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Streaming with pointer wrap
    step();
    max_cnt = 0;
    rx0 = rx_cnt;
    wr_valid = 1;
    for (int i = 0; i < 20; i++) begin
      wr_data = N'(8'h40 + i);
      @(negedge clk);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      step();
    end
    wr_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      step();
    end
    rd_ready = 0;
    @(negedge clk);
    chk("stream_rx", rx_cnt - rx0, 20);
    chk("stream_max_le2", (max_cnt <= 2), 1);
    chk("stream_sb_empty", sb.size(), 0);

    // Flush with live data
    step();
    wr_valid = 1;
    for (int i = 0; i < 6; i++) begin
      wr_data = N'(8'h60 + i);
      step();
    end
    wr_valid = 0;
    step();
    @(negedge clk);
    chk("pre_flush_count", count, 5);
    chk("pre_flush_rd_valid", rd_valid, 1);
    step();
    flush = 1; wr_valid = 1; wr_data = 8'hEE;
    @(negedge clk);
    chk("flush_wr_ready", wr_ready, 0);
    step();
    flush = 0; wr_valid = 0;
    @(negedge clk);
    chk("flush_count", count, 0);
    chk("flush_rd_valid", rd_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("flush_no_stale", rd_valid, 0);
    end
    step();
    wr_valid = 1; wr_data = 8'h3C;
    step();
    wr_valid = 0;
    step();
    @(negedge clk);
    chk("post_flush_valid", rd_valid, 1);
    chk("post_flush_data", rd_data, 8'h3C);
    step();
    rd_ready = 1;
    step();
    rd_ready = 0;

    // Asynchronous reset mid-operation
    wr_valid = 1;
    for (int i = 0; i < 5; i++) begin
      wr_data = N'(8'h80 + i);
      step();
    end
    wr_valid = 0;
    step();
    @(negedge clk);
    chk("pre_rst_count", count, 4);
    step();
    #2 arst_n = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_wr_ready", wr_ready, 1);
    step();
    #2 arst_n = 1;
    step();
    wr_valid = 1; wr_data = 8'h77;
    @(negedge clk);
    chk("arst_wptr0", mem_address_w, 0);
    step();
    wr_valid = 0;
    step();
    @(negedge clk);
    chk("arst_resume_valid", rd_valid, 1);
    chk("arst_resume_data", rd_data, 8'h77);
    step();
    rd_ready = 1;
    step();
    rd_ready = 0;
    @(negedge clk);
    chk("arst_resume_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
